fpnew_wb_queue: RTL and testbench
=================================

Name: fpnew_wb_queue

Overview:
Result write-back queue sitting directly downstream of the FPU top-level output handshake (result/status/tag, valid/ready). It buffers up to Depth completed results so a stalled register-file write port does not back-pressure the FPU pipelines. It also keeps the architectural sticky exception flags (fflags) by OR-accumulating the status of every retired entry. It supports the FPU flush semantics.

Parameters:
Width, 64, result width in bits; matches FPU Features.Width.
TagType, logic, type of the operation tag carried with each result.
Depth, 4, number of queue entries; legal range 2..16, need not be a power of two.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
flush_i  in  1  discard all queued entries
in_result_i  in  Width  result from FPU
in_status_i  in  5 (fpnew_pkg::status_t)  exception flags of the result
in_tag_i  in  TagType  tag of the result
in_valid_i  in  1  upstream valid
in_ready_o  out  1  queue can accept
out_result_o  out  Width  head result
out_status_o  out  5  head status
out_tag_o  out  TagType  head tag
out_valid_o  out  1  head valid
out_ready_i  in  1  consumer accepts head
fflags_o  out  5  sticky accumulated exception flags
fflags_clr_i  in  1  clear sticky flags
busy_o  out  1  entries held

Behaviour:
- Storage: circular buffer, write pointer wr_q, read pointer rd_q, occupancy cnt_q (0..Depth). Each pointer wraps from Depth-1 to 0.
- Push: in_valid_i & in_ready_o. Pop: out_valid_o & out_ready_i.
- in_ready_o = (cnt_q != Depth). It is a registered-state function only: no combinational path from out_ready_i. When full, a same-cycle pop does not enable a push.
- out_valid_o = (cnt_q != 0). out_* drive the entry at rd_q.
- Latency: a result pushed in cycle N is visible at the output in cycle N+1.
- Simultaneous push and pop with 0 < cnt_q < Depth: cnt_q is unchanged and both pointers advance.
- Payload of a held head must stay stable while out_valid_o=1 and out_ready_i=0.
- Sticky flags:
  - On every pop, fflags_q |= out_status_o.
  - fflags_clr_i zeroes fflags_q. If a clear and a pop happen in the same cycle, the next fflags_q equals the popped status, so new flags survive the clear.
  - fflags_o = fflags_q.
- Flush:
  - flush_i=1: next cycle cnt_q, wr_q and rd_q are all 0.
  - Any push or pop in the flush cycle is discarded, and a pop in that cycle does not update fflags.
  - fflags_q is not affected by flush.
  - in_ready_o and out_valid_o in the flush cycle keep their normal state-derived values.
- busy_o = (cnt_q != 0).
- Reset (rst_i sampled high on a clock edge): cnt_q, wr_q, rd_q and fflags_q all go to 0. Reset during operation drops every entry.
- Post-reset outputs: out_valid_o=0, in_ready_o=1, fflags_o=0, busy_o=0. Payload outputs are don't-care (storage is not reset).
- Reset has priority over flush, and flush has priority over push and pop.

Optional Feature:
Macro FPNEW_WB_BYPASS_EN.
- Defined:
  - When cnt_q==0 and in_valid_i=1, out_valid_o=1 and out_* are taken combinationally from in_*.
  - If out_ready_i=1, the result retires in the same cycle (fflags updated) and is not written into storage.
  - If out_ready_i=0, the result is pushed normally.
  - Latency becomes 0 when empty.
- Undefined: the registered-only path above, with latency 1.

Decomposition:
- fpnew_pkg: the existing status_t is used. Add localparam NUM_FFLAGS=5 and function wb_ptr_inc(ptr, depth), which handles wrap-around for non-power-of-two depths.
- Sub-module: fpnew_wb_storage, a Depth x {result, status, tag} register array with write port (we, waddr, wdata) and read port (raddr, rdata). No reset on data.
- Pointer, count, flag and bypass logic remain in fpnew_wb_queue.

Test Plan:
- Fill/drain: Depth=4, out_ready_i=0, push tags 1,2,3,4 → in_ready_o=0 after the 4th push. Push of tag 5 held while blocked. Then out_ready_i=1 → tags pop in order 1,2,3,4, and tag 5 is accepted in the cycle after the first pop.
- Concurrent push/pop: at cnt=2, push and pop every cycle for 10 cycles → cnt stays 2, order preserved, and pointers wrap correctly past index 3. Repeat with Depth=3.
- Sticky flags: retire statuses 5'b00001 (NX) then 5'b10000 (NV) → fflags_o=5'b10001. Assert fflags_clr_i in the same cycle as popping a 5'b00100 (OF) result → fflags_o=5'b00100.
- Flush: with 3 entries queued, assert flush_i alongside in_valid_i and out_ready_i → next cycle out_valid_o=0 and busy_o=0, the flush-cycle push is lost, and fflags_o is unchanged.
- Reset mid-traffic: cnt=2 with fflags=5'b00011, assert rst_i for 1 cycle → out_valid_o=0, in_ready_o=1, fflags_o=0. A subsequent push of tag 7 appears 1 cycle later.
- Bypass (FPNEW_WB_BYPASS_EN): queue empty, in_valid_i=1 with tag 9 and out_ready_i=1 → out_valid_o=1 with tag 9 in the same cycle and busy_o remains 0. Without the macro, tag 9 appears one cycle later.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FPU types plus helpers for the result write-back queue.
package fpnew_pkg;

  // IEEE 754 exception flags; NV is the most significant bit.
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  localparam int unsigned NUM_FFLAGS = 5;

  // Widest pointer the queue can need (Depth is at most 16).
  localparam int unsigned WB_PTR_W = 4;

  // Circular pointer increment.
  // Wraps explicitly at depth-1, so it also works when depth is not a power of two.
  function automatic logic [WB_PTR_W-1:0] wb_ptr_inc(input logic [WB_PTR_W-1:0] ptr,
                                                     input int unsigned depth);
    if (32'(ptr) == depth - 1) return '0;
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/fpnew_wb_storage.sv
// Entry array for the write-back queue: one write port, one asynchronous read port.
// The data is deliberately not reset; the occupancy counter decides validity.
module fpnew_wb_storage #(
  parameter int unsigned EntW  = 8,
  parameter int unsigned Depth = 4,
  parameter int unsigned AddrW = 2
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [EntW-1:0]  wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [EntW-1:0]  rdata
);

  logic [EntW-1:0] mem_q [Depth];

  // Capture the pushed entry.
  always_ff @(posedge clk_i) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fpnew_wb_queue.sv
// FPU result write-back queue with sticky fflags accumulation and flush.
// Optional macro FPNEW_WB_BYPASS_EN: when the queue is empty, an incoming
// result is presented at the output in the same cycle. If it is accepted
// there, it retires without being written into storage.
module fpnew_wb_queue
  import fpnew_pkg::*;
#(
  parameter int unsigned Width   = 64,
  parameter type         TagType = logic,
  parameter int unsigned Depth   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [Width-1:0] in_result_i,
  input  status_t          in_status_i,
  input  TagType           in_tag_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_result_o,
  output status_t          out_status_o,
  output TagType           out_tag_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output status_t          fflags_o,
  input  logic             fflags_clr_i,
  output logic             busy_o
);

  localparam int unsigned TagW  = $bits(TagType);
  localparam int unsigned EntW  = Width + NUM_FFLAGS + TagW;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic [AddrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  status_t          fflags_q, fflags_d;
  logic [EntW-1:0]  wdata, rdata;
  logic             empty, full, bypass, push, pop, retire;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(Depth));

`ifdef FPNEW_WB_BYPASS_EN
  assign bypass = empty & in_valid_i;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty | bypass;
  assign busy_o      = ~empty;
  assign fflags_o    = fflags_q;

  // A bypassed result that is accepted immediately never touches storage.
  assign push   = in_valid_i & in_ready_o & ~(bypass & out_ready_i);
  assign pop    = ~empty & out_ready_i;
  assign retire = out_valid_o & out_ready_i;

  assign wdata = {in_result_i, in_status_i, in_tag_i};
  assign {out_result_o, out_status_o, out_tag_o} =
      bypass ? {in_result_i, in_status_i, in_tag_i} : rdata;

  fpnew_wb_storage #(
    .EntW  (EntW),
    .Depth (Depth),
    .AddrW (AddrW)
  ) i_storage (
    .clk_i (clk_i),
    .we    (push & ~flush_i),
    .waddr (wr_q),
    .wdata (wdata),
    .raddr (rd_q),
    .rdata (rdata)
  );

  // Next-state logic for pointers, occupancy and sticky flags.
  // A flush discards the cycle's push and pop but leaves the flags alone.
  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    fflags_d = fflags_q;
    if (fflags_clr_i) fflags_d = '0;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = AddrW'(wb_ptr_inc(WB_PTR_W'(wr_q), Depth));
      if (pop)  rd_d = AddrW'(wb_ptr_inc(WB_PTR_W'(rd_q), Depth));
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      // OR-ing into the already-cleared value lets flags from a same-cycle pop survive a clear.
      if (retire) fflags_d = fflags_d | out_status_o;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      fflags_q <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      fflags_q <= fflags_d;
    end
  end

endmodule

// File: tb/tb_fpnew_wb_queue.sv
// Directed self-checking bench for fpnew_wb_queue (Depth=4 and Depth=3 instances).
module tb_fpnew_wb_queue;
  import fpnew_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, clr;
  logic [63:0] in_result;
  status_t     in_status;
  logic [7:0]  in_tag;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [63:0] a_result;
  status_t     a_status, a_fflags;
  logic [7:0]  a_tag;

  logic        b_in_ready, b_out_valid, b_busy;
  logic [63:0] b_result;
  status_t     b_status, b_fflags;
  logic [7:0]  b_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpnew_wb_queue #(.Width(64), .TagType(logic [7:0]), .Depth(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_result_i(in_result), .in_status_i(in_status), .in_tag_i(in_tag),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .out_result_o(a_result), .out_status_o(a_status), .out_tag_o(a_tag),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .fflags_o(a_fflags), .fflags_clr_i(clr), .busy_o(a_busy)
  );

  fpnew_wb_queue #(.Width(64), .TagType(logic [7:0]), .Depth(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_result_i(in_result), .in_status_i(in_status), .in_tag_i(in_tag),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .out_result_o(b_result), .out_status_o(b_status), .out_tag_o(b_tag),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .fflags_o(b_fflags), .fflags_clr_i(clr), .busy_o(b_busy)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] t, input logic [4:0] st);
    in_valid  = v;
    in_tag    = t;
    in_status = st;
    in_result = {48'hCAFE_0000_0000, 8'h00, t};
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; clr = 1'b0;
    set_in(1'b0, 8'h00, 5'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; clr = 1'b0;
    set_in(1'b0, 8'h00, 5'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_fflags", 64'(a_fflags), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);

    // Fill/drain: four pushes with the consumer stalled, tag 5 held off.
    for (int t = 1; t <= 4; t++) begin
      set_in(1'b1, 8'(t), 5'b0);
      tick();
    end
    set_in(1'b1, 8'd5, 5'b0);
    #1;
    chk("fill_in_ready", 64'(a_in_ready), 64'd0);
    chk("fill_d3_in_ready", 64'(b_in_ready), 64'd0);
    chk("fill_head_tag", 64'(a_tag), 64'd1);
    chk("fill_head_result", a_result, 64'hCAFE_0000_0000_0001);
    tick();
    chk("hold_head_tag", 64'(a_tag), 64'd1);
    chk("hold_in_ready", 64'(a_in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("drain_tag1", 64'(a_tag), 64'd1);
    tick();
    chk("drain_tag2", 64'(a_tag), 64'd2);
    chk("drain_ready_after_pop", 64'(a_in_ready), 64'd1);
    tick();
    set_in(1'b0, 8'd0, 5'b0);
    #1;
    for (int t = 3; t <= 5; t++) begin
      chk("drain_order", 64'(a_tag), 64'(t));
      tick();
    end
    chk("drain_empty", 64'(a_out_valid), 64'd0);

    // Concurrent push/pop at occupancy 2, both depths.
    do_reset();
    set_in(1'b1, 8'd10, 5'b0); tick();
    set_in(1'b1, 8'd11, 5'b0); tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 8'(12 + i), 5'b0);
      #1;
      chk("conc_d4_head", 64'(a_tag), 64'(10 + i));
      chk("conc_d3_head", 64'(b_tag), 64'(10 + i));
      tick();
    end
    set_in(1'b0, 8'd0, 5'b0);
    out_ready = 1'b0;
    #1;
    chk("conc_d4_head20", 64'(a_tag), 64'd20);
    chk("conc_d3_head20", 64'(b_tag), 64'd20);
    chk("conc_d3_in_ready", 64'(b_in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("conc_d4_head21", 64'(a_tag), 64'd21);
    chk("conc_d3_head21", 64'(b_tag), 64'd21);
    tick();
    chk("conc_d4_empty", 64'(a_out_valid), 64'd0);
    chk("conc_d3_empty", 64'(b_busy), 64'd0);

    // Sticky flags: NX then NV, then clear alongside an OF pop.
    do_reset();
    set_in(1'b1, 8'd30, 5'b00001); tick();
    set_in(1'b1, 8'd31, 5'b10000); tick();
    set_in(1'b0, 8'd0, 5'b0);
    out_ready = 1'b1;
    tick();
    chk("flags_nx", 64'(a_fflags), 64'b00001);
    tick();
    chk("flags_nx_nv", 64'(a_fflags), 64'b10001);
    out_ready = 1'b0;
    set_in(1'b1, 8'd32, 5'b00100); tick();
    set_in(1'b0, 8'd0, 5'b0);
    out_ready = 1'b1; clr = 1'b1;
    tick();
    out_ready = 1'b0; clr = 1'b0;
    #1;
    chk("flags_clr_pop", 64'(a_fflags), 64'b00100);

    // Flush with 3 entries queued, alongside a push and a pop.
    set_in(1'b1, 8'd40, 5'b10000); tick();
    set_in(1'b1, 8'd41, 5'b10000); tick();
    set_in(1'b1, 8'd42, 5'b10000); tick();
    set_in(1'b1, 8'd43, 5'b01000);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("flush_cyc_out_valid", 64'(a_out_valid), 64'd1);
    chk("flush_cyc_in_ready", 64'(a_in_ready), 64'd1);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 8'd0, 5'b0);
    #1;
    chk("flush_out_valid", 64'(a_out_valid), 64'd0);
    chk("flush_busy", 64'(a_busy), 64'd0);
    chk("flush_fflags", 64'(a_fflags), 64'b00100);
    tick();
    chk("flush_push_lost", 64'(a_busy), 64'd0);

    // Reset in the middle of traffic.
    do_reset();
    set_in(1'b1, 8'd50, 5'b00001); tick();
    set_in(1'b1, 8'd51, 5'b00010); tick();
    set_in(1'b0, 8'd0, 5'b0);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    set_in(1'b1, 8'd52, 5'b0); tick();
    set_in(1'b1, 8'd53, 5'b0); tick();
    set_in(1'b0, 8'd0, 5'b0);
    #1;
    chk("mid_fflags", 64'(a_fflags), 64'b00011);
    chk("mid_busy", 64'(a_busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("mid_rst_fflags", 64'(a_fflags), 64'd0);
    set_in(1'b1, 8'd7, 5'b0);
    #1;
`ifdef FPNEW_WB_BYPASS_EN
    chk("tag7_same_cycle", 64'(a_out_valid), 64'd1);
`else
    chk("tag7_same_cycle", 64'(a_out_valid), 64'd0);
`endif
    tick();
    set_in(1'b0, 8'd0, 5'b0);
    #1;
    chk("tag7_valid", 64'(a_out_valid), 64'd1);
    chk("tag7_tag", 64'(a_tag), 64'd7);

    // Bypass path from empty with the consumer ready.
    do_reset();
    set_in(1'b1, 8'd9, 5'b00001);
    out_ready = 1'b1;
    #1;
`ifdef FPNEW_WB_BYPASS_EN
    chk("byp_valid", 64'(a_out_valid), 64'd1);
    chk("byp_tag", 64'(a_tag), 64'd9);
    chk("byp_busy", 64'(a_busy), 64'd0);
    tick();
    set_in(1'b0, 8'd0, 5'b0);
    #1;
    chk("byp_after_valid", 64'(a_out_valid), 64'd0);
    chk("byp_after_busy", 64'(a_busy), 64'd0);
    chk("byp_fflags", 64'(a_fflags), 64'b00001);
`else
    chk("nobyp_valid", 64'(a_out_valid), 64'd0);
    tick();
    set_in(1'b0, 8'd0, 5'b0);
    #1;
    chk("nobyp_after_valid", 64'(a_out_valid), 64'd1);
    chk("nobyp_tag", 64'(a_tag), 64'd9);
    chk("nobyp_fflags_pre", 64'(a_fflags), 64'd0);
    tick();
    chk("nobyp_fflags", 64'(a_fflags), 64'b00001);
    chk("nobyp_empty", 64'(a_busy), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
